// File: rtl/cpu_types_pkg.sv
// Shared core types: opcodes, MEMctrl bit indices and the hazard-unit state encoding.
// Also holds the helper that decides which ID instructions read rt as a source.
package cpu_types_pkg;

    typedef enum logic [5:0] {
        RTYPE = 6'b000000,
        J     = 6'b000010,
        JAL   = 6'b000011,
        BEQ   = 6'b000100,
        BNE   = 6'b000101,
        ADDI  = 6'b001000,
        ADDIU = 6'b001001,
        SLTI  = 6'b001010,
        SLTIU = 6'b001011,
        ANDI  = 6'b001100,
        ORI   = 6'b001101,
        XORI  = 6'b001110,
        LUI   = 6'b001111,
        LW    = 6'b100011,
        LBU   = 6'b100100,
        LHU   = 6'b100101,
        SB    = 6'b101000,
        SH    = 6'b101001,
        SW    = 6'b101011,
        LL    = 6'b110000,
        SC    = 6'b111000,
        HALT  = 6'b111111
    } opcode_t;

    // Bit positions inside the 5-bit MEMctrl field carried down the pipe.
    localparam int unsigned MEM_DREN = 0;
    localparam int unsigned MEM_DWEN = 1;
    localparam int unsigned MEM_BR   = 2;

    typedef enum logic [1:0] {
        HzRun,
        HzMemWait,
        HzHalt
    } hz_state_t;

    function automatic logic reads_rt(input logic [5:0] op);
        return (op == RTYPE) || (op == BEQ) || (op == BNE) || (op == SW);
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != '1)) begin
            q_d = q_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and flow-control unit: stage enables, flush strobes, halt latch and debug counters
// for the 5-stage pipeline. Enables and strobes are purely combinational on state and inputs.
module hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [31:0]      id_instr,
    input  logic [31:0]      ex_instr,
    input  logic             ex_dREN,
    input  logic [4:0]       ex_wsel,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             cnt_clr,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             flush_IDEX,
    output logic             exmem_en,
    output logic             halted,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_state_t state_q;
    hz_state_t state_d;
    logic      halted_q;
    logic      halted_d;

    logic [5:0] id_op;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       ex_halt;
    logic       mem_stall;
    logic       load_use;
    logic       run_eval;
    logic       bubble_inc;
    logic       flush_inc;
    logic       unused_bits;

    assign id_op     = id_instr[31:26];
    assign id_rs     = id_instr[25:21];
    assign id_rt     = id_instr[20:16];
    assign ex_halt   = (ex_instr[31:26] == HALT);
    assign mem_stall = mem_req && !dhit;
    assign load_use  = ex_dREN && (ex_wsel != 5'd0) &&
                       ((ex_wsel == id_rs) || (reads_rt(id_op) && (ex_wsel == id_rt)));

    assign unused_bits = ^{id_instr[15:0], ex_instr[25:0]};

    // MEMWAIT with dhit behaves exactly like a RUN cycle, including its transitions.
    always_comb begin
        run_eval = 1'b0;
        unique case (state_q)
            HzRun:     run_eval = 1'b1;
            HzMemWait: run_eval = dhit;
            default:   run_eval = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_en    = 1'b0;
        flush_IDEX = 1'b0;
        exmem_en   = 1'b0;
        bubble_inc = 1'b0;
        flush_inc  = 1'b0;

        if (state_q != HzRun && state_q != HzMemWait && state_q != HzHalt) begin
            state_d = HzRun;
        end else if (run_eval) begin
            if (ex_halt) begin
                state_d = HzHalt;
            end else if (mem_stall) begin
                state_d = HzMemWait;
            end else begin
                state_d = HzRun;
                if (ihit) begin
                    pc_en    = 1'b1;
                    ifid_en  = 1'b1;
                    idex_en  = 1'b1;
                    exmem_en = 1'b1;
                    // A redirect squashes the ID instruction, so its load-use hazard is moot.
                    if (ex_redirect) begin
                        ifid_flush = 1'b1;
                        flush_IDEX = 1'b1;
                        flush_inc  = 1'b1;
                    end else if (load_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        flush_IDEX = 1'b1;
                        bubble_inc = 1'b1;
                    end
                end
            end
        end
    end

    assign halted_d = (state_d == HzHalt);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= HzRun;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    assign halted = halted_q;

    sat_counter #(
        .W (CNT_W)
    ) u_bubble_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .clr  (cnt_clr),
        .inc  (bubble_inc),
        .q    (bubble_cnt)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .clr  (cnt_clr),
        .inc  (flush_inc),
        .q    (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against a
// behavioural model of the stall/flush rules.
module tb_hazard_ctrl;

    localparam int unsigned CW   = 4;
    localparam int          CMAX = 15;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          ihit;
    logic          dhit;
    logic [31:0]   id_instr;
    logic [31:0]   ex_instr;
    logic          ex_dREN;
    logic [4:0]    ex_wsel;
    logic          ex_redirect;
    logic          mem_req;
    logic          cnt_clr;
    logic          pc_en;
    logic          ifid_en;
    logic          ifid_flush;
    logic          idex_en;
    logic          flush_IDEX;
    logic          exmem_en;
    logic          halted;
    logic [CW-1:0] bubble_cnt;
    logic [CW-1:0] flush_cnt;
    logic [5:0]    en_vec;

    always #5 CLK = ~CLK;

    hazard_ctrl #(
        .CNT_W (CW)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .dhit        (dhit),
        .id_instr    (id_instr),
        .ex_instr    (ex_instr),
        .ex_dREN     (ex_dREN),
        .ex_wsel     (ex_wsel),
        .ex_redirect (ex_redirect),
        .mem_req     (mem_req),
        .cnt_clr     (cnt_clr),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .ifid_flush  (ifid_flush),
        .idex_en     (idex_en),
        .flush_IDEX  (flush_IDEX),
        .exmem_en    (exmem_en),
        .halted      (halted),
        .bubble_cnt  (bubble_cnt),
        .flush_cnt   (flush_cnt)
    );

    // {pc_en, ifid_en, ifid_flush, idex_en, flush_IDEX, exmem_en}
    assign en_vec = {pc_en, ifid_en, ifid_flush, idex_en, flush_IDEX, exmem_en};

    localparam logic [5:0] EN_NONE  = 6'b000000;
    localparam logic [5:0] EN_ALL   = 6'b110101;
    localparam logic [5:0] EN_FLUSH = 6'b111111;
    localparam logic [5:0] EN_BUBB  = 6'b000111;

    localparam logic [31:0] ADD_3_5_2 = {6'd0, 5'd5, 5'd2, 5'd3, 5'd0, 6'h20};
    localparam logic [31:0] LW_5_0_4  = {6'd35, 5'd4, 5'd5, 16'd0};
    localparam logic [31:0] HALT_INS  = 32'hFC00_0000;

    int n_checks = 0;
    int n_errors = 0;

    // Model: mode 0 = running, 1 = waiting on data memory, 2 = halted.
    int m_mode;
    int m_bub;
    int m_fl;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_eval(output logic [5:0] en, output int nxt, output bit binc,
                              output bit finc);
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        bit         src_rt;
        bit         luse;
        op     = id_instr[31:26];
        rs     = id_instr[25:21];
        rt     = id_instr[20:16];
        src_rt = (op == 6'd0) || (op == 6'd4) || (op == 6'd5) || (op == 6'd43);
        luse   = ex_dREN && (ex_wsel != 0) && ((ex_wsel == rs) || (src_rt && ex_wsel == rt));
        en     = EN_NONE;
        nxt    = m_mode;
        binc   = 1'b0;
        finc   = 1'b0;
        if (m_mode == 2 || (m_mode == 1 && !dhit)) return;
        if (ex_instr[31:26] == 6'h3f) begin
            nxt = 2;
        end else if (mem_req && !dhit) begin
            nxt = 1;
        end else begin
            nxt = 0;
            if (ihit) begin
                if (ex_redirect) begin
                    en   = EN_FLUSH;
                    finc = 1'b1;
                end else if (luse) begin
                    en   = EN_BUBB;
                    binc = 1'b1;
                end else begin
                    en = EN_ALL;
                end
            end
        end
    endtask

    // Called ~1ns after a rising edge with inputs already applied; returns 1ns after the next.
    task automatic cycle(input string tag);
        logic [5:0] en;
        int         nxt;
        bit         binc;
        bit         finc;
        #1;
        model_eval(en, nxt, binc, finc);
        check_val($sformatf("%s.en", tag), 32'(en_vec), 32'(en));
        check_val($sformatf("%s.halted", tag), 32'(halted), 32'(m_mode == 2));
        check_val($sformatf("%s.bubble_cnt", tag), 32'(bubble_cnt), 32'(m_bub));
        check_val($sformatf("%s.flush_cnt", tag), 32'(flush_cnt), 32'(m_fl));
        @(posedge CLK);
        m_mode = nxt;
        if (cnt_clr) begin
            m_bub = 0;
            m_fl  = 0;
        end else begin
            if (binc && m_bub < CMAX) m_bub++;
            if (finc && m_fl < CMAX) m_fl++;
        end
        #1;
    endtask

    task automatic do_reset(input string tag);
        logic [5:0] en;
        int         nxt;
        bit         binc;
        bit         finc;
        nRST   = 1'b0;
        #1;
        m_mode = 0;
        m_bub  = 0;
        m_fl   = 0;
        model_eval(en, nxt, binc, finc);
        check_val($sformatf("%s.rst_halted", tag), 32'(halted), 32'd0);
        check_val($sformatf("%s.rst_bubble", tag), 32'(bubble_cnt), 32'd0);
        check_val($sformatf("%s.rst_flush", tag), 32'(flush_cnt), 32'd0);
        check_val($sformatf("%s.rst_en", tag), 32'(en_vec), 32'(en));
        #1;
        nRST = 1'b1;
    endtask

    task automatic set_idle();
        ihit        = 1'b1;
        dhit        = 1'b1;
        id_instr    = 32'd0;
        ex_instr    = 32'd0;
        ex_dREN     = 1'b0;
        ex_wsel     = 5'd0;
        ex_redirect = 1'b0;
        mem_req     = 1'b0;
        cnt_clr     = 1'b0;
    endtask

    task automatic randomize_inputs();
        logic [5:0]  ops [8];
        logic [31:0] r;
        logic [31:0] s;
        ops = '{6'd0, 6'd4, 6'd5, 6'd43, 6'd35, 6'd8, 6'd13, 6'd2};
        r = $urandom();
        s = $urandom();
        ihit        = ($urandom_range(0, 9) < 8);
        dhit        = ($urandom_range(0, 9) < 6);
        mem_req     = ($urandom_range(0, 9) < 3);
        ex_redirect = ($urandom_range(0, 19) < 3);
        ex_dREN     = ($urandom_range(0, 1) == 1);
        ex_wsel     = 5'($urandom_range(0, 7));
        cnt_clr     = ($urandom_range(0, 19) == 0);
        id_instr    = {ops[$urandom_range(0, 7)], 2'b00, r[2:0], 2'b00, r[5:3], r[15:0]};
        if ($urandom_range(0, 39) == 0) ex_instr = HALT_INS;
        else ex_instr = {ops[$urandom_range(0, 7)], s[25:0]};
    endtask

    initial begin
        int halt_cycles;
        nRST = 1'b0;
        set_idle();
        m_mode = 0;
        m_bub  = 0;
        m_fl   = 0;
        @(posedge CLK);
        #1;
        do_reset("init");

        // Load-use on rs: one bubble.
        id_instr = ADD_3_5_2;
        ex_dREN  = 1'b1;
        ex_wsel  = 5'd5;
        #1;
        check_val("lu_en", 32'(en_vec), 32'(EN_BUBB));
        cycle("lu");
        check_val("lu_bubble_after", 32'(bubble_cnt), 32'd1);

        // Destination $0 never stalls.
        ex_wsel = 5'd0;
        #1;
        check_val("lu_r0_en", 32'(en_vec), 32'(EN_ALL));
        cycle("lu_r0");
        check_val("lu_r0_bubble", 32'(bubble_cnt), 32'd1);

        // lw writes rt, so a match on rt only is no hazard.
        id_instr = LW_5_0_4;
        ex_wsel  = 5'd5;
        #1;
        check_val("lw_rt_en", 32'(en_vec), 32'(EN_ALL));
        cycle("lw_rt");

        // Redirect outranks load-use.
        id_instr    = ADD_3_5_2;
        ex_redirect = 1'b1;
        #1;
        check_val("redir_en", 32'(en_vec), 32'(EN_FLUSH));
        cycle("redir");
        check_val("redir_flush_cnt", 32'(flush_cnt), 32'd1);
        check_val("redir_bubble_cnt", 32'(bubble_cnt), 32'd1);

        // Memory wait: three stalled cycles, then release on dhit.
        set_idle();
        mem_req = 1'b1;
        dhit    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("memwait_en", 32'(en_vec), 32'(EN_NONE));
            cycle("memwait");
        end
        dhit = 1'b1;
        #1;
        check_val("memwait_release_en", 32'(en_vec), 32'(EN_ALL));
        cycle("memwait_release");
        mem_req = 1'b0;
        #1;
        check_val("memwait_back_run", 32'(en_vec), 32'(EN_ALL));
        cycle("memwait_run");

        // Halt holds until reset.
        ex_instr = HALT_INS;
        cycle("halt_enter");
        ex_instr = 32'd0;
        for (int i = 0; i < 4; i++) begin
            check_val("halt_halted", 32'(halted), 32'd1);
            check_val("halt_en", 32'(en_vec), 32'(EN_NONE));
            cycle("halt_hold");
        end
        do_reset("halt_rst");
        check_val("halt_rst_en", 32'(en_vec), 32'(EN_ALL));
        cycle("post_halt");

        // Saturation at 15 and clear priority.
        do_reset("sat");
        id_instr = ADD_3_5_2;
        ex_dREN  = 1'b1;
        ex_wsel  = 5'd5;
        for (int i = 0; i < 20; i++) cycle("sat");
        check_val("sat_bubble_15", 32'(bubble_cnt), 32'd15);
        cnt_clr = 1'b1;
        cycle("clr");
        check_val("clr_bubble_0", 32'(bubble_cnt), 32'd0);
        cnt_clr = 1'b0;

        // Randomized traffic against the model.
        do_reset("rand_start");
        halt_cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            if (m_mode == 2) halt_cycles++;
            else halt_cycles = 0;
            randomize_inputs();
            if (halt_cycles > 2) begin
                ex_instr = 32'd0;
                do_reset("rand_rst");
                halt_cycles = 0;
            end
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
